// File: rtl/frame_read_ctrl_pkg.sv
// Shared types and widths for the frame buffer read controller.
// Holds the fetch FSM encoding plus address, pixel and burst-length widths.
// Also provides the burst sizing helper used when a request is built.
package frame_read_ctrl_pkg;

  localparam int ADDR_W = 24;
  localparam int PIX_W  = 16;
  localparam int LEN_W  = 8;
  localparam int REM_W  = 22;   // enough for 2047 x 2047 pixels

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SPACE = 3'd1,
    REQ        = 3'd2,
    RECV       = 3'd3,
    DRAIN      = 3'd4
  } state_t;

  // Next burst is the full burst length unless fewer pixels remain in the frame.
  function automatic logic [LEN_W-1:0] burst_len_for(input logic [REM_W-1:0] remaining,
                                                     input int unsigned      burst);
    if (remaining < REM_W'(burst)) begin
      return remaining[LEN_W-1:0];
    end
    return LEN_W'(burst);
  endfunction

endpackage

// File: rtl/frame_read_ctrl_pix_sync_fifo.sv
// Single-clock pixel FIFO with flush, occupancy count and registered read port.
// Latency: a popped word appears on rd_data one cycle after rd_en.
// Backpressure: none; a read of an empty FIFO returns zero and leaves pointers alone.
module pix_sync_fifo
  import frame_read_ctrl_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int W     = PIX_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty = (count == '0);
  // Writes are never issued alongside a flush by the controller; the guard keeps it safe anyway.
  assign do_wr = wr_en && !flush;
  assign do_rd = rd_en && !empty;

  // Storage array: written on accepted writes, no reset needed.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; flush returns the FIFO to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered read port: reads see the contents before any same-cycle flush,
  // an empty read yields zero, and the output holds when not reading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= empty ? '0 : mem[rd_ptr];
    end
  end

endmodule

// File: rtl/frame_read_ctrl.sv
// Fetches one video frame from memory in bursts into a local FIFO feeding the display.
// Latency: pixel on rd_data one cycle after rd_en; first request two cycles after frame start.
// Backpressure: requests wait for a full burst of FIFO space; mem_req holds until mem_ack.
module frame_read_ctrl
  import frame_read_ctrl_pkg::*;
#(
  parameter int                BURST_LEN  = 128,
  parameter int                FIFO_DEPTH = 512,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 24'd0
) (
  input  logic              hdmi_clk,
  input  logic              rst_n,
  input  logic              video_vs,
  input  logic [10:0]       h_disp,
  input  logic [10:0]       v_disp,
  input  logic              rd_en,
  output logic [PIX_W-1:0]  rd_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LEN_W-1:0]  mem_len,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              underflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  logic               vs_q;
  logic               frame_start;
  logic [REM_W-1:0]   remaining;
  logic [REM_W-1:0]   frame_pixels;
  logic [LEN_W-1:0]   beat;
  logic               last_beat;
  logic               restart;
  logic               fifo_wr;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [CNT_W-1:0]   free_words;
  logic               space_ok;
  logic               rd_miss;

  assign frame_start  = video_vs && !vs_q;
  assign frame_pixels = REM_W'(h_disp) * REM_W'(v_disp);
  assign free_words   = CNT_W'(FIFO_DEPTH) - fifo_count;
  assign space_ok     = (free_words >= CNT_W'(BURST_LEN));
  // beat never exceeds mem_len-1, so the 8-bit increment cannot wrap.
  assign last_beat    = mem_rvalid && ((beat + LEN_W'(1)) == mem_len);
  // Only beats of a live burst are stored; a frame start turns the current beat into a discard.
  assign fifo_wr      = (state == RECV) && mem_rvalid && !frame_start;
  assign rd_miss      = rd_en && fifo_empty;

  // Decide when the frame-start initialisation takes effect: immediately when no burst
  // is outstanding, otherwise once the last beat of the abandoned burst has gone by.
  always_comb begin
    restart = 1'b0;
    case (state)
      IDLE, WAIT_SPACE: restart = frame_start;
      REQ:              restart = frame_start && !mem_ack;
      RECV:             restart = frame_start && last_beat;
      DRAIN:            restart = last_beat;
      default:          restart = 1'b0;
    endcase
  end

  // Previous vsync sample for rising-edge detection.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
    end else begin
      vs_q <= video_vs;
    end
  end

  // Burst fetch FSM with registered request outputs.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_len   <= '0;
      beat      <= '0;
      remaining <= '0;
    end else if (restart) begin
      mem_req   <= 1'b0;
      mem_addr  <= BASE_ADDR;
      remaining <= frame_pixels;
      beat      <= '0;
      state     <= WAIT_SPACE;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        WAIT_SPACE: begin
          if (remaining == '0) begin
            state <= IDLE;
          end else if (space_ok) begin
            mem_len <= burst_len_for(remaining, BURST_LEN);
            mem_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // A frame start without acceptance is handled by restart above.
          if (mem_ack) begin
            mem_req <= 1'b0;
            beat    <= '0;
            state   <= frame_start ? DRAIN : RECV;
          end
        end
        RECV: begin
          if (frame_start) begin
            // The final-beat case is covered by restart; here beats are still owed.
            if (mem_rvalid) begin
              beat <= beat + LEN_W'(1);
            end
            state <= DRAIN;
          end else if (mem_rvalid) begin
            if (last_beat) begin
              mem_addr  <= mem_addr + ADDR_W'(mem_len);
              remaining <= remaining - REM_W'(mem_len);
              state     <= WAIT_SPACE;
            end else begin
              beat <= beat + LEN_W'(1);
            end
          end
        end
        DRAIN: begin
          if (mem_rvalid) begin
            beat <= beat + LEN_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Sticky underflow flag; a frame start clears it, but a miss in that same cycle still counts.
  always_ff @(posedge hdmi_clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (restart) begin
      underflow <= rd_miss;
    end else if (rd_miss) begin
      underflow <= 1'b1;
    end
  end

  pix_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PIX_W)
  ) u_fifo (
    .clk     (hdmi_clk),
    .rst_n   (rst_n),
    .flush   (restart),
    .wr_en   (fifo_wr),
    .wr_data (mem_rdata),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_frame_read_ctrl.sv
// Randomised scoreboard bench for frame_read_ctrl with a queue-level reference model.
// Stimulus runs at the falling edge; a separate monitor compares outputs shortly after.
// A watchdog ends the run if anything stalls.
module tb_frame_read_ctrl;

  localparam int          BL = 4;
  localparam int          FD = 16;
  localparam logic [23:0] BA = 24'd0;

  logic        hdmi_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        video_vs = 1'b0;
  logic [10:0] h_disp = '0;
  logic [10:0] v_disp = '0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [7:0]  mem_len;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        underflow;

  always #5 hdmi_clk = ~hdmi_clk;

  frame_read_ctrl #(.BURST_LEN(BL), .FIFO_DEPTH(FD), .BASE_ADDR(BA)) dut (
    .hdmi_clk   (hdmi_clk),
    .rst_n      (rst_n),
    .video_vs   (video_vs),
    .h_disp     (h_disp),
    .v_disp     (v_disp),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_len    (mem_len),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .underflow  (underflow)
  );

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  len;
  } req_t;

  int          n_checks = 0;
  int          n_fail = 0;
  // reference model state
  req_t        exp_req[$];
  logic [15:0] mq[$];
  logic [15:0] exp_pix[$];
  logic        exp_uf = 1'b0;
  logic [15:0] last_rd = '0;
  int          beats_left = 0;
  bit          draining = 1'b0;
  bit          vs_prev = 1'b0;
  // memory model state
  logic [15:0] beat_q[$];
  bit          pend_accept = 1'b0;
  logic [23:0] pend_addr = '0;
  logic [7:0]  pend_len = '0;
  int          beat_in_burst = 0;
  // knobs
  int          rd_rate = 0;
  bit          ack_hold = 1'b0;
  bit          monitor_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected burst list for a whole frame: BL-sized chunks from BA, last chunk shorter.
  task automatic build_frame();
    int unsigned rem;
    logic [23:0] a;
    req_t r;
    exp_req.delete();
    rem = int'(h_disp) * int'(v_disp);
    a = BA;
    while (rem > 0) begin
      r.addr = a;
      r.len = 8'((rem < BL) ? rem : BL);
      exp_req.push_back(r);
      a = a + 24'(r.len);
      rem = rem - int'(r.len);
    end
  endtask

  // Effect of the rising edge just passed, using the inputs that were held across it.
  task automatic model_step();
    bit fs;
    bit miss;
    bit rd;
    req_t r;
    fs = video_vs && !vs_prev;
    vs_prev = video_vs;
    miss = 1'b0;
    rd = 1'b0;
    if (rd_en) begin
      rd = 1'b1;
      if (mq.size() > 0) last_rd = mq.pop_front();
      else begin
        last_rd = 16'h0000;
        miss = 1'b1;
      end
    end
    if (pend_accept) begin
      if (exp_req.size() > 0) begin
        r = exp_req.pop_front();
        beats_left = int'(r.len);
      end else begin
        beats_left = int'(pend_len);
      end
      for (int i = 0; i < int'(pend_len); i++) beat_q.push_back(16'(pend_addr + 24'(i)));
      beat_in_burst = 0;
      pend_accept = 1'b0;
    end else if (mem_rvalid && beats_left > 0) begin
      if (!draining && !fs) mq.push_back(mem_rdata);
      beats_left--;
    end
    if (fs && beats_left > 0) begin
      draining = 1'b1;
    end else if (fs || (draining && beats_left == 0)) begin
      mq.delete();
      build_frame();
      exp_uf = 1'b0;
      draining = 1'b0;
    end
    if (miss) exp_uf = 1'b1;
    if (rd) exp_pix.push_back(last_rd);
  endtask

  // Memory responder and display reader for the next rising edge.
  task automatic drive_inputs();
    mem_ack = 1'b0;
    if (mem_req && !ack_hold && $urandom_range(0, 2) == 0) begin
      mem_ack = 1'b1;
      pend_accept = 1'b1;
      pend_addr = mem_addr;
      pend_len = mem_len;
    end
    mem_rvalid = 1'b0;
    if (beat_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      mem_rvalid = 1'b1;
      mem_rdata = beat_q.pop_front();
      beat_in_burst++;
    end
    rd_en = (rd_rate > 0) && ($urandom_range(0, 99) < rd_rate);
  endtask

  task automatic tick();
    @(negedge hdmi_clk);
    model_step();
    drive_inputs();
  endtask

  task automatic start_frame(input int h, input int v);
    h_disp = 11'(h);
    v_disp = 11'(v);
    video_vs = 1'b1;
    tick();
    tick();
    video_vs = 1'b0;
  endtask

  function automatic bit frame_idle();
    return exp_req.size() == 0 && beats_left == 0 && !draining && beat_q.size() == 0 && !pend_accept;
  endfunction

  task automatic run_to_done(input int budget);
    int n = 0;
    while (!frame_idle() && n < budget) begin
      tick();
      n++;
    end
    check("frame_done", 32'(frame_idle()), 32'd1);
  endtask

  task automatic drain_reads(input int budget);
    int n = 0;
    rd_rate = 100;
    while (mq.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    rd_rate = 0;
    repeat (3) tick();
  endtask

  // Scoreboard monitor: pops one expected pixel per read, otherwise checks hold,
  // and checks any visible request against the expected burst at the head of the list.
  initial begin
    forever begin
      @(negedge hdmi_clk);
      #1;
      if (monitor_on) begin
        if (exp_pix.size() > 0) check("rd_data", 32'(rd_data), 32'(exp_pix.pop_front()));
        else check("rd_data_hold", 32'(rd_data), 32'(last_rd));
        check("underflow", 32'(underflow), 32'(exp_uf));
        if (mem_req) begin
          if (exp_req.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_req: addr 0x%0h len %0d, expected no request", mem_addr, mem_len);
          end else begin
            check("mem_addr", 32'(mem_addr), 32'(exp_req[0].addr));
            check("mem_len", 32'(mem_len), 32'(exp_req[0].len));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int n;
    // Reset values while reset is held.
    repeat (3) @(negedge hdmi_clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_len", 32'(mem_len), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    rst_n = 1'b1;
    monitor_on = 1'b1;

    // No request before the first frame start.
    repeat (20) tick();

    // 4x2 frame: two bursts at 0 and 4, then 8 reads return 0..7.
    start_frame(4, 2);
    run_to_done(300);
    repeat (4) tick();
    rd_rate = 100;
    repeat (8) tick();
    rd_rate = 0;
    repeat (2) tick();
    check("t1_last_pixel", 32'(last_rd), 32'd7);

    // 10x1 frame: bursts 4,4,2 then idle.
    rd_rate = 50;
    start_frame(10, 1);
    run_to_done(400);
    drain_reads(100);
    repeat (20) tick();

    // Reads before any data arrives underflow with zero data.
    rd_rate = 100;
    start_frame(8, 1);
    tick();
    rd_rate = 0;
    tick();
    check("t3_underflow_set", 32'(underflow), 32'd1);
    check("t3_rd_zero", 32'(rd_data), 32'd0);
    run_to_done(300);
    drain_reads(100);

    // Frame start after beat 2 of a burst: remainder discarded, restart at BA.
    start_frame(16, 1);
    check("t3_underflow_clear", 32'(underflow), 32'd0);
    n = 0;
    while (beat_in_burst < 2 && n < 200) begin
      tick();
      n++;
    end
    check("t4_reached_beat2", 32'(beat_in_burst >= 2), 32'd1);
    start_frame(16, 1);
    run_to_done(400);
    drain_reads(100);

    // Request held without acceptance stays stable.
    ack_hold = 1'b1;
    start_frame(8, 1);
    repeat (22) tick();
    check("t5_req_held", 32'(mem_req), 32'd1);
    ack_hold = 1'b0;
    run_to_done(300);
    drain_reads(100);

    // Asynchronous reset in the middle of a burst.
    rd_rate = 30;
    start_frame(16, 1);
    n = 0;
    while (!(exp_req.size() == 2 && beats_left > 0) && n < 300) begin
      tick();
      n++;
    end
    check("t6_in_recv", 32'(exp_req.size() == 2 && beats_left > 0), 32'd1);
    monitor_on = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_mem_req", 32'(mem_req), 32'd0);
    check("t6_mem_addr", 32'(mem_addr), 32'd0);
    check("t6_mem_len", 32'(mem_len), 32'd0);
    check("t6_rd_data", 32'(rd_data), 32'd0);
    check("t6_underflow", 32'(underflow), 32'd0);
    rd_rate = 0;
    rd_en = 1'b0;
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    video_vs = 1'b0;
    exp_req.delete();
    mq.delete();
    exp_pix.delete();
    beat_q.delete();
    exp_uf = 1'b0;
    last_rd = '0;
    beats_left = 0;
    draining = 1'b0;
    vs_prev = 1'b0;
    pend_accept = 1'b0;
    repeat (3) @(negedge hdmi_clk);
    rst_n = 1'b1;
    monitor_on = 1'b1;
    repeat (30) tick();
    rd_rate = 50;
    start_frame(6, 2);
    run_to_done(400);
    drain_reads(100);

    // Random frames, some restarted part way through.
    for (int f = 0; f < 8; f++) begin
      rd_rate = $urandom_range(20, 90);
      start_frame($urandom_range(1, 40), $urandom_range(1, 3));
      if (f % 3 == 1) begin
        repeat ($urandom_range(3, 40)) tick();
        start_frame($urandom_range(1, 30), $urandom_range(1, 2));
      end
      run_to_done(2000);
      drain_reads(200);
      repeat ($urandom_range(0, 10)) tick();
    end

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_read_ctrl.md
FRAME_READ_CTRL -- requirements
Module: frame_read_ctrl

Interface
REQ-001 Parameters, one per line:
- BURST_LEN, 128, words per memory read burst (1..255)
- FIFO_DEPTH, 512, local pixel FIFO depth in 16-bit words (power of two, >= 2*BURST_LEN)
- BASE_ADDR, 24'd0, word address of the frame buffer's first pixel
REQ-002 Ports, one per line:
- hdmi_clk  in  1  pixel clock; only clock
- rst_n  in  1  asynchronous active-low reset
- video_vs  in  1  display vertical sync, active high; rising edge = frame start
- h_disp  in  11  active pixels per line
- v_disp  in  11  active lines per frame
- rd_en  in  1  pixel request from the display stage
- rd_data  out  16  RGB565 pixel, valid one cycle after rd_en
- mem_req  out  1  burst read request
- mem_addr  out  24  burst start word address
- mem_len  out  8  burst length in words
- mem_ack  in  1  request accepted; accepted in the cycle where mem_req && mem_ack
- mem_rvalid  in  1  read word valid
- mem_rdata  in  16  read word
- underflow  out  1  sticky: rd_en seen with FIFO empty

Function
REQ-003 Frame start is detected by registering video_vs; a frame start is video_vs=1 with previous video_vs=0.
REQ-004 On frame start, the block SHALL flush the FIFO, set address to BASE_ADDR, load remaining=h_disp*v_disp (22-bit), and clear underflow.
REQ-005 FSM states: IDLE, WAIT_SPACE, REQ, RECV, DRAIN. Reset enters IDLE.
REQ-006 IDLE -> WAIT_SPACE on frame start; otherwise remain in IDLE.
REQ-007 WAIT_SPACE -> REQ when remaining>0 and FIFO free words >= BURST_LEN; if remaining==0, go to IDLE.
REQ-008 In REQ, mem_req=1 with mem_addr and mem_len held stable until mem_ack; mem_len=min(BURST_LEN, remaining); REQ -> RECV on acceptance.
REQ-009 In RECV, each mem_rvalid writes mem_rdata to the FIFO and increments the beat counter; on the beat equal to mem_len, address+=mem_len and remaining-=mem_len, then go to WAIT_SPACE.
REQ-010 If a frame start occurs in RECV, the block SHALL enter DRAIN, discard the remaining beats of the outstanding burst without writing them, and then apply REQ-004 and go to WAIT_SPACE.
REQ-011 If a frame start occurs in REQ before acceptance, the block SHALL drop mem_req, apply REQ-004, and go to WAIT_SPACE. If acceptance and the frame start occur in the same cycle, the block SHALL go to DRAIN.
REQ-012 If a frame start occurs in WAIT_SPACE or IDLE, the block SHALL apply REQ-004 and go to (or stay in) WAIT_SPACE.
REQ-013 rd_en with a non-empty FIFO SHALL pop one word, and rd_data SHALL present that word in the next cycle; a simultaneous write and read SHALL keep the count unchanged.
REQ-014 rd_en with an empty FIFO SHALL produce rd_data=16'h0000 in the next cycle and set underflow; the FIFO pointers SHALL not move.
REQ-015 rd_data SHALL hold its last value when rd_en=0.
REQ-016 FIFO writes never overflow by construction (REQ-007); mem_rvalid outside RECV/DRAIN is ignored.

Reset
REQ-017 Asynchronous assertion on rst_n low forces state=IDLE and mem_req=0, and clears mem_addr, mem_len, rd_data, underflow, FIFO pointers, count, beat counter and remaining; deassertion is used as-is (synchronised upstream).
REQ-018 No memory request SHALL issue after reset until the first frame start.

Structure
REQ-019 A shared package holds the FSM state enum, address width (24), pixel width (16) and length width (8).
REQ-020 One sub-module, pix_sync_fifo (single-clock FIFO with one-cycle registered read, count output, flush input), is instantiated once.

Verification
REQ-021 Test 1: h_disp=4, v_disp=2, BURST_LEN=4, memory returns incrementing data -> two bursts at addr 0 and 4, length 4, and 8 rd_en pulses return 0..7 in order.
REQ-022 Test 2: h_disp=10, v_disp=1, BURST_LEN=4 -> bursts of length 4, 4, 2 at addresses 0, 4, 8, then IDLE.
REQ-023 Test 3: rd_en asserted before any data arrives -> rd_data=0 and underflow=1; underflow clears on the next frame start.
REQ-024 Test 4: frame start after beat 2 of a 4-beat burst -> beats 3 and 4 are discarded, the next mem_addr=BASE_ADDR, and the FIFO is empty.
REQ-025 Test 5: mem_ack held low for 20 cycles -> mem_req, mem_addr and mem_len stay stable throughout.
REQ-026 Test 6: rst_n pulled low during RECV -> all outputs reach their reset values without waiting for a clock edge, and no request issues until the next frame start.
